// File: rtl/pixel_shift_reg_pkg.sv
// Shared pipeline types for the LED serial-decode chain: decoder strobes,
// pixel-stage state encoding and sizing helpers.
package pipeline_types;

  localparam int PIXEL_BITS_DEFAULT = 24;

  typedef struct packed {
    logic decode_bit;
    logic valid;
    logic treset;
  } shift_reg_input_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } pixel_state_t;

  localparam pixel_state_t PIXEL_STATE_RESET = IDLE;

  // Counter must be able to hold the value BITS_PER_PIXEL itself.
  function automatic int pixel_cnt_w(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/pixel_shift_reg_if.sv
// Bit-strobe link from the stage-2 decoder into the pixel shift register.
interface pixel_shift_reg_if;
  import pipeline_types::*;

  shift_reg_input_t sr;

  modport master (output sr);
  modport slave  (input  sr);

endinterface

// File: rtl/pixel_shift_reg.sv
// Pixel assembler: collects MSB-first bits, latches on treset, handles surplus
// bits. Define PIXEL_FWD_EN to forward surplus bits instead of flagging overrun.
module pixel_shift_reg
  import pipeline_types::*;
#(
  parameter int BITS_PER_PIXEL = PIXEL_BITS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pixel_shift_reg_if.slave          i_sr,
  output logic [BITS_PER_PIXEL-1:0] o_pixel,
  output logic                      o_pixel_update,
  output logic                      o_short_frame,
  output logic                      o_busy,
  output logic                      o_fwd_bit,
  output logic                      o_fwd_valid,
  output logic                      o_overrun
);

  localparam int               CNT_W = pixel_cnt_w(BITS_PER_PIXEL);
  localparam logic [CNT_W-1:0] CNT_N = CNT_W'(BITS_PER_PIXEL);

  pixel_state_t              r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [BITS_PER_PIXEL-1:0] r_shift;
  logic [BITS_PER_PIXEL-1:0] r_pixel;
  logic                      r_update;
  logic                      r_short;
  logic                      r_busy;

  pixel_state_t              w_state_nxt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [CNT_W-1:0]          w_cnt_inc;
  logic [BITS_PER_PIXEL-1:0] w_shift_nxt;
  logic [BITS_PER_PIXEL-1:0] w_pixel_nxt;
  logic                      w_update_nxt;
  logic                      w_short_nxt;
  logic                      w_surplus;
  logic                      w_valid;
  logic                      w_bit;
  logic                      w_treset;

  assign w_valid   = i_sr.sr.valid;
  assign w_bit     = i_sr.sr.decode_bit;
  assign w_treset  = i_sr.sr.treset;
  assign w_cnt_inc = (r_cnt == CNT_N) ? r_cnt : r_cnt + CNT_W'(1);

  // treset takes priority over valid in every state, so a colliding bit is dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_pixel_nxt  = r_pixel;
    w_update_nxt = 1'b0;
    w_short_nxt  = 1'b0;
    w_surplus    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_treset && w_valid) begin
          w_shift_nxt = {r_shift[BITS_PER_PIXEL-2:0], w_bit};
          w_cnt_nxt   = w_cnt_inc;
          w_state_nxt = (w_cnt_inc == CNT_N) ? FULL : COLLECT;
        end
      end
      COLLECT: begin
        if (w_treset) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_short_nxt = 1'b1;
        end else if (w_valid) begin
          w_shift_nxt = {r_shift[BITS_PER_PIXEL-2:0], w_bit};
          w_cnt_nxt   = w_cnt_inc;
          if (w_cnt_inc == CNT_N) begin
            w_state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (w_treset) begin
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
          w_pixel_nxt  = r_shift;
          w_update_nxt = 1'b1;
        end else if (w_valid) begin
          w_surplus = 1'b1;
        end
      end
      default: begin
        w_state_nxt = PIXEL_STATE_RESET;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= PIXEL_STATE_RESET;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_pixel  <= '0;
      r_update <= 1'b0;
      r_short  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_pixel  <= w_pixel_nxt;
      r_update <= w_update_nxt;
      r_short  <= w_short_nxt;
      r_busy   <= (w_state_nxt != IDLE);
    end
  end

  assign o_pixel        = r_pixel;
  assign o_pixel_update = r_update;
  assign o_short_frame  = r_short;
  assign o_busy         = r_busy;

`ifdef PIXEL_FWD_EN
  logic r_fwd_bit;
  logic r_fwd_valid;

  // Surplus bits re-emerge one cycle later in the same strobe format.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_bit   <= 1'b0;
      r_fwd_valid <= 1'b0;
    end else begin
      r_fwd_valid <= w_surplus;
      r_fwd_bit   <= w_surplus & w_bit;
    end
  end

  assign o_fwd_bit   = r_fwd_bit;
  assign o_fwd_valid = r_fwd_valid;
  assign o_overrun   = 1'b0;
`else
  logic r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_treset) begin
      r_overrun <= 1'b0;
    end else if (w_surplus) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_fwd_bit   = 1'b0;
  assign o_fwd_valid = 1'b0;
  assign o_overrun   = r_overrun;
`endif

endmodule

// File: tb/tb_pixel_shift_reg.sv
// Scoreboard bench for pixel_shift_reg: directed scenarios plus random frames
// checked against a queue-based pixel model.
module tb_pixel_shift_reg;
  import pipeline_types::*;

  localparam int N = PIXEL_BITS_DEFAULT;

  typedef struct {
    int          kind;   // 0 update, 1 short frame, 2 forwarded bit
    logic [31:0] val;
  } ev_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] o_pixel;
  logic         o_pixel_update;
  logic         o_short_frame;
  logic         o_busy;
  logic         o_fwd_bit;
  logic         o_fwd_valid;
  logic         o_overrun;

  pixel_shift_reg_if sr_if ();

  pixel_shift_reg #(.BITS_PER_PIXEL(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_sr           (sr_if.slave),
    .o_pixel        (o_pixel),
    .o_pixel_update (o_pixel_update),
    .o_short_frame  (o_short_frame),
    .o_busy         (o_busy),
    .o_fwd_bit      (o_fwd_bit),
    .o_fwd_valid    (o_fwd_valid),
    .o_overrun      (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits collected so far, displayed pixel, overrun flag.
  logic        m_bits[$];
  logic [31:0] m_pixel;
  logic        m_overrun;
  ev_t         evq[$];

  int errors;
  int checks;

  task automatic model_reset();
    m_bits.delete();
    m_pixel   = '0;
    m_overrun = 1'b0;
    evq.delete();
  endtask

  task automatic model_step(input logic v, input logic b, input logic t);
    logic [31:0] val;
    if (t) begin
      if (m_bits.size() == N) begin
        val = '0;
        foreach (m_bits[i]) val = {val[30:0], m_bits[i]};
        m_pixel = val;
        evq.push_back('{0, val});
      end else if (m_bits.size() > 0) begin
        evq.push_back('{1, m_pixel});
      end
      m_bits.delete();
      m_overrun = 1'b0;
    end else if (v) begin
      if (m_bits.size() < N) begin
        m_bits.push_back(b);
      end else begin
`ifdef PIXEL_FWD_EN
        evq.push_back('{2, {31'b0, b}});
`else
        m_overrun = 1'b1;
`endif
      end
    end
  endtask

  task automatic step(input logic v, input logic b, input logic t);
    sr_if.sr.valid      = v;
    sr_if.sr.decode_bit = b;
    sr_if.sr.treset     = t;
    @(posedge clk);
    #1;
    if (rst_n) model_step(v, b, t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) step(1'b1, w[i], 1'b0);
  endtask

  task automatic assert_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic release_reset();
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: compares outputs against the model and pops expected pulses.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_event(input int kind, input logic [31:0] act);
    ev_t e;
    if (evq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: got kind %0d value 0x%0h, want no pulse at %0t", kind, act, $time);
    end else begin
      e = evq.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_value", act, e.val);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      chk("pixel", 32'(o_pixel), m_pixel);
      chk("busy", 32'(o_busy), 32'(m_bits.size() != 0));
      chk("overrun", 32'(o_overrun), 32'(m_overrun));
      if (!o_fwd_valid) chk("fwd_bit_idle", 32'(o_fwd_bit), 32'd0);
      if (o_pixel_update) expect_event(0, 32'(o_pixel));
      if (o_short_frame) expect_event(1, 32'(o_pixel));
      if (o_fwd_valid) expect_event(2, 32'(o_fwd_bit));
      checks++;
      if (evq.size() != 0) begin
        errors++;
        $display("FAIL missing_pulse: got no pulse, want kind %0d value 0x%0h at %0t",
                 evq[0].kind, evq[0].val, $time);
        evq.delete();
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          len;
    model_reset();
    rst_n    = 1'b0;
    sr_if.sr = '0;

    // Reset with random input activity.
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'($urandom), 1'($urandom));
    release_reset();
    idle(3);

    // Nominal frame.
    send_word(32'hA5C3F0, N);
    step(1'b0, 1'b0, 1'b1);
    idle(3);

    // Surplus bits.
    send_word(32'h123456, N);
    send_word(32'b101101, 6);
    step(1'b0, 1'b0, 1'b1);
    idle(3);

    // Short frame after preload.
    send_word(32'hFFFFFF, N);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    send_word(32'h2AB, 10);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    idle(2);

    // Collision: 24th bit coincides with treset.
    send_word(32'h7FFFFF, N - 1);
    step(1'b1, 1'b1, 1'b1);
    idle(2);

    // Mid-pixel asynchronous reset.
    send_word(32'hABC, 12);
    assert_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    release_reset();
    idle(2);
    send_word(32'h00FF00, N);
    step(1'b0, 1'b0, 1'b1);
    idle(3);

    // Random frames, gaps, collisions and repeated tresets.
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(0, N + 6);
      w   = $urandom;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom), 1'b0);
        step(1'b1, w[i % 32], 1'b0);
      end
      if ($urandom_range(0, 4) == 0) step(1'b1, 1'($urandom), 1'b1);
      else                           step(1'b0, 1'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b1);
      idle($urandom_range(0, 2));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
